md_issue_ctrl: RTL

Issue controller in front of the multiply/divide unit (MD: start/opt/v1/v2 in; busy/hi/lo out; opt 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; busy rises the cycle after start).
- Buffers MD ops from the E stage in a small FIFO and launches them one at a time.
- Closes the start-to-busy gap, so no op is lost and no HI/LO read can see stale data.
- Gates mfhi/mflo reads with a valid/ready handshake; the pipeline stalls on !ready.

---
 rtl/md_issue_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: FIFO-buffered issue control for the multiply/divide unit.
// Optional feature macro: MD_PERF_CNT_EN (launch and read-stall counters).
module md_issue_ctrl #(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_opt,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        rd_valid,
  input  logic        rd_sel,
  output logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        md_start,
  output logic [2:0]  md_opt,
  output logic [31:0] md_v1,
  output logic [31:0] md_v2,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo
`ifdef MD_PERF_CNT_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_stall
`endif
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int PW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [2:0]  opt;
    logic [31:0] a;
    logic [31:0] b;
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  md_op_t fifo_q [QDEPTH];
  md_op_t head;
  md_op_t op_q, op_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] occ;
  logic [AW-1:0] wr_idx, rd_idx;

  logic full, empty;
  logic push, pop, pop_ok;
  logic quiet;

  generate
    if (QDEPTH == 1) begin : g_one
      assign wr_idx = '0;
      assign rd_idx = '0;
    end else begin : g_idx
      assign wr_idx = wr_ptr_q[AW-1:0];
      assign rd_idx = rd_ptr_q[AW-1:0];
    end
  endgenerate

  // Occupancy via the extra pointer bit; ranges 0..QDEPTH.
  assign occ   = wr_ptr_q - rd_ptr_q;
  assign full  = (occ == PW'(QDEPTH));
  assign empty = (occ == '0);

  assign req_ready = !full && !flush;

  // Opcodes 11x are accepted but never reach the MD unit.
  assign push   = req_valid && req_ready && (req_opt[2:1] != 2'b11);
  assign pop_ok = !empty && !flush;
  assign head   = fifo_q[rd_idx];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_idx] <= '{opt: req_opt, a: req_a, b: req_b};
    end
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    op_d     = op_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop_ok) begin
          pop     = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (!md_busy) begin
          if (pop_ok) begin
            pop     = 1'b1;
            state_d = S_LAUNCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      op_d     = head;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      op_q     <= op_d;
    end
  end

  assign md_start = (state_q == S_LAUNCH);
  assign md_opt   = op_q.opt;
  assign md_v1    = op_q.a;
  assign md_v2    = op_q.b;

  // HI/LO are stable only with nothing queued and nothing in flight.
  assign quiet = empty &&
                 ((state_q == S_IDLE) ||
                  ((state_q == S_WAIT) && !md_busy));

  assign rd_ready = rd_valid && quiet;
  assign rd_data  = !rd_ready ? 32'd0 :
                    rd_sel    ? md_lo : md_hi;

`ifdef MD_PERF_CNT_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (state_q == S_LAUNCH) begin
        perf_ops_q <= perf_ops_q + 32'd1;
      end
      if (rd_valid && !rd_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
